// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline skid registers: occupancy state encoding
// and the default bubble payload (reset-vector PC paired with a NOP opcode).
package pipe_pkg;

  // Encodings double as the live-entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // {PC = 0xBFC00000, instruction = addi x0,x0,0} reads as a harmless NOP.
  localparam logic [63:0] BUBBLE_DEFAULT = {32'hBFC00000, 32'h00000013};

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register. MAIN drives the outputs; SKID catches the
// item accepted in the cycle a stall first becomes visible, which lets
// in_ready come straight from a flop instead of from out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(BUBBLE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  skid_state_e       state_p0;
  skid_state_e       state_nxt;
  logic              in_ready_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic [DATA_W-1:0] skid_data_p0;

  logic accept;
  logic transfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  assign accept   = in_valid && in_ready_p0;
  assign transfer = out_valid && out_ready;

  // Next-state and data-steering decode; flush overrides everything but reset.
  always_comb begin
    state_nxt      = state_p0;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    unique case (state_p0)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !transfer) begin
          state_nxt    = ST_FULL;
          load_skid_in = 1'b1;
        end else if (!accept && transfer) begin
          state_nxt = ST_EMPTY;
        end else if (accept && transfer) begin
          load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (transfer) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // Control state: occupancy and the registered ready, reset to empty/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_EMPTY;
      in_ready_p0 <= 1'b1;
    end else begin
      state_p0    <= state_nxt;
      in_ready_p0 <= (state_nxt != ST_FULL);
    end
  end

  // Payload registers carry no reset; the bubble mux hides stale contents.
  always_ff @(posedge clk) begin
    if (load_main_in) begin
      main_data_p0 <= in_data;
    end else if (load_main_skid) begin
      main_data_p0 <= skid_data_p0;
    end
    if (load_skid_in) begin
      skid_data_p0 <= in_data;
    end
  end

  assign in_ready  = in_ready_p0;
  assign out_valid = (state_p0 != ST_EMPTY);
  assign out_data  = out_valid ? main_data_p0 : BUBBLE_DATA;
  assign occupancy = state_p0;

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the payload width (e.g. PC concatenated with instruction).
REQ-002 SHALL have parameter BUBBLE_DATA, default {32'hBFC00000, 32'h00000013}, giving the payload driven when the output is invalid.
REQ-003 SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a live entry.
- out_ready  in  1  downstream accepts; deasserted means stall.
- out_data  out  DATA_W  head payload; BUBBLE_DATA when out_valid=0.
- occupancy  out  2  number of live entries, 0 to 2.

Function
REQ-005 SHALL hold two entries: MAIN, which drives the outputs, and SKID, which catches data accepted while the output is stalled.
REQ-006 SHALL implement states EMPTY (0 entries), ONE (MAIN valid) and FULL (MAIN and SKID valid); occupancy SHALL equal 0, 1 and 2 respectively.
REQ-007 An accept SHALL occur when in_valid&&in_ready; a transfer SHALL occur when out_valid&&out_ready.
REQ-008 in_ready SHALL be 1 exactly when the state is not FULL, driven from a flop with no combinational path from out_ready.
REQ-009 Transitions:
- EMPTY + accept -> ONE; in_data goes to MAIN.
- ONE + accept, no transfer -> FULL; in_data goes to SKID.
- ONE + transfer, no accept -> EMPTY.
- ONE + accept + transfer -> ONE; in_data goes to MAIN.
- FULL + transfer -> ONE; SKID moves to MAIN.
- All other combinations hold the state.
REQ-010 Latency SHALL be one cycle from accept to out_valid when the stage is EMPTY.
REQ-011 Throughput SHALL be one item per cycle when out_ready is held at 1.
REQ-012 Entries SHALL leave in acceptance order; none SHALL be lost or duplicated.
REQ-013 While out_valid=0, out_data SHALL equal BUBBLE_DATA, so an invalid slot reads as a NOP.
REQ-014 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-015 flush=1 SHALL, on the next edge, give EMPTY with in_ready=1 and out_data=BUBBLE_DATA.
REQ-016 An accept and a transfer in the same cycle as flush SHALL both be discarded.
REQ-017 rst SHALL take priority over flush.

Reset
REQ-018 On rst=1 the stage SHALL enter EMPTY with out_valid=0, in_ready=1, occupancy=0 and out_data=BUBBLE_DATA.
REQ-019 Reset asserted mid-operation SHALL discard both entries regardless of out_ready.
REQ-020 The first accept SHALL occur no earlier than the cycle after rst deasserts.

Structure
REQ-021 The state enum typedef (EMPTY/ONE/FULL) and the default BUBBLE constant SHALL live in shared package pipe_pkg.
REQ-022 No sub-module is needed; one flopped state register plus two DATA_W data registers is sufficient.
REQ-023 The block SHALL be instantiable as IF/ID, ID/EX and EX/MEM registers by setting DATA_W only.

Verification
REQ-024 Reset: after rst, check out_valid=0, out_data=64'hBFC00000_00000013, in_ready=1 and occupancy=0.
REQ-025 Streaming: out_ready=1, push A1..A4 back-to-back -> A1..A4 appear on consecutive cycles starting one cycle after the first accept, occupancy=1 throughout.
REQ-026 Stall: push A, B with out_ready=0 -> occupancy=2, in_ready=0, out_data=A stable; raise out_ready -> A then B, and in_ready returns to 1 after the first transfer.
REQ-027 Flush while FULL with in_valid=1 carrying C -> next cycle occupancy=0, out_data=BUBBLE_DATA and C is never output.
REQ-028 Simultaneous events: in ONE, accept D and transfer at once -> state stays ONE and out_data=D on the next cycle.
REQ-029 Random stimulus: random in_valid and out_ready over 10k cycles against a FIFO scoreboard -> no loss, reordering or duplication, and no in_ready dependence on same-cycle out_ready.
